prog_inst_mem: RTL and testbench

PROG_INST_MEM -- requirements
Module: prog_inst_mem

---
 rtl/prog_inst_mem.sv | 132 +++++++++++++
 tb/tb_prog_inst_mem.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_inst_mem.sv
// prog_inst_mem: byte-serial program loader into a word RAM, plus a fixed-latency fetch port.
// A zero-length load goes straight to RUN, so no loader byte can ever be written by it.
module prog_inst_mem #(
    parameter int unsigned ADDR_W     = 12,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [ADDR_W-2:0] ld_nwords,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic              f_valid,
    output logic [31:0]       f_inst,
    output logic              f_misalign
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [ADDR_W-2:0] PTR_ONE = 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-2:0] cnt_q, cnt_d;
    logic [ADDR_W-2:0] ptr_q, ptr_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              ld_done_q, ld_done_d;
    logic              byte_acc, we;
    logic [31:0]       wdata;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;
    logic        f_valid_q, mis_q, zero_q;
    logic        f_acc, f_mis;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        ld_done_d = ld_done_q;
        we        = 1'b0;
        wdata     = BIG_ENDIAN ? {asm_q, ld_byte} : {ld_byte, asm_q};
        ld_ready  = (state_q == StLoad);
        f_ready   = (state_q == StRun);
        // ld_start wins over a byte offered in the same cycle; that byte is dropped
        byte_acc  = ld_valid && ld_ready && !ld_start;

        if (ld_start) begin
            cnt_d  = ld_nwords;
            ptr_d  = '0;
            bcnt_d = '0;
            if (ld_nwords == '0) begin
                state_d   = StRun;
                ld_done_d = 1'b1;
            end else begin
                state_d   = StLoad;
                ld_done_d = 1'b0;
            end
        end else if (byte_acc) begin
            bcnt_d = bcnt_q + 2'd1;
            asm_d  = BIG_ENDIAN ? {asm_q[15:0], ld_byte} : {ld_byte, asm_q[23:8]};
            if (bcnt_q == 2'd3) begin
                we    = 1'b1;
                ptr_d = ptr_q + PTR_ONE;
                if (ptr_d == cnt_q) begin
                    state_d   = StRun;
                    ld_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            ld_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            ld_done_q <= ld_done_d;
        end
    end

    assign f_acc = f_req && f_ready;
    assign f_mis = (f_addr[1:0] != 2'b00);

    // Block RAM: no reset, single write port, registered read enabled only by aligned fetches
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr_q[ADDR_W-3:0]] <= wdata;
        end
        if (f_acc && !f_mis) begin
            rd_q <= mem[f_addr[ADDR_W-1:2]];
        end
    end

    // zero_q masks the RAM output after reset and for misaligned fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_valid_q <= 1'b0;
            mis_q     <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            f_valid_q <= f_acc;
            if (f_acc) begin
                mis_q  <= f_mis;
                zero_q <= f_mis;
            end
        end
    end

    assign ld_done    = ld_done_q;
    assign f_valid    = f_valid_q;
    assign f_misalign = mis_q;
    assign f_inst     = zero_q ? 32'h0 : rd_q;

endmodule

// File: tb/tb_prog_inst_mem.sv
// tb_prog_inst_mem: scenario tasks plus randomized loads/fetches checked against a word-array model.
// Two instances share all inputs: big-endian (default) and little-endian assembly.
module tb_prog_inst_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_start = 1'b0;
    logic [10:0] ld_nwords = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        f_req = 1'b0;
    logic [11:0] f_addr = '0;

    logic        ld_ready, ld_done, f_ready, f_valid, f_misalign;
    logic [31:0] f_inst;
    logic        le_ld_ready, le_ld_done, le_f_ready, le_f_valid, le_f_misalign;
    logic [31:0] f_inst_le;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: expected word contents for each byte order
    logic [31:0] mdl_be [1024];
    logic [31:0] mdl_le [1024];

    prog_inst_mem dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_nwords(ld_nwords),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_done(ld_done),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_valid(f_valid),
        .f_inst(f_inst), .f_misalign(f_misalign)
    );

    prog_inst_mem #(.ADDR_W(12), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_nwords(ld_nwords),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(le_ld_ready), .ld_done(le_ld_done),
        .f_req(f_req), .f_addr(f_addr), .f_ready(le_f_ready), .f_valid(le_f_valid),
        .f_inst(f_inst_le), .f_misalign(le_f_misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int n);
        ld_start  = 1'b1;
        ld_nwords = 11'(n);
        tick();
        ld_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic set_word(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        mdl_be[idx] = {b0, b1, b2, b3};
        mdl_le[idx] = {b3, b2, b1, b0};
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({ld_ready, ld_done, f_ready, f_valid, f_misalign} !== 5'b0 || f_inst !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b done=%b frdy=%b fv=%b mis=%b inst=%h want all 0",
                     ld_ready, ld_done, f_ready, f_valid, f_misalign, f_inst);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_fetch();
        f_req  = 1'b1;
        f_addr = 12'h000;
        #1;
        n_cmp++;
        if (f_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_f_ready: got %b want 0", f_ready);
        end
        tick();
        f_req = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b0 || f_inst !== 32'h0) begin
            n_bad++;
            $display("FAIL idle_f_valid: got valid=%b inst=%h want 0/00000000", f_valid, f_inst);
        end
    endtask

    task automatic test_load_fetch();
        logic [7:0] bytes [8];
        bytes = '{8'h13, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00, 8'h6F};
        start_load(2);
        n_cmp++;
        if (ld_ready !== 1'b1 || ld_done !== 1'b0) begin
            n_bad++;
            $display("FAIL load_enter: got rdy=%b done=%b want 1/0", ld_ready, ld_done);
        end
        for (int i = 0; i < 8; i++) push_byte(bytes[i]);
        set_word(0, 8'h13, 8'h00, 8'h00, 8'h93);
        set_word(1, 8'h01, 8'h00, 8'h00, 8'h6F);
        n_cmp++;
        if (ld_done !== 1'b1 || ld_ready !== 1'b0 || f_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL load_done: got done=%b rdy=%b frdy=%b want 1/0/1",
                     ld_done, ld_ready, f_ready);
        end
        f_req  = 1'b1;
        f_addr = 12'h000;
        tick();
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== 32'h13000093 || f_inst_le !== 32'h93000013) begin
            n_bad++;
            $display("FAIL fetch_word0: got v=%b be=%h le=%h want 1/13000093/93000013",
                     f_valid, f_inst, f_inst_le);
        end
        f_addr = 12'h004;
        tick();
        f_req = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== 32'h0100006F || f_misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_word1: got v=%b inst=%h mis=%b want 1/0100006f/0",
                     f_valid, f_inst, f_misalign);
        end
        tick();
        n_cmp++;
        if (f_valid !== 1'b0 || f_inst !== 32'h0100006F) begin
            n_bad++;
            $display("FAIL fetch_hold: got v=%b inst=%h want 0/0100006f", f_valid, f_inst);
        end
    endtask

    task automatic test_misalign();
        f_req  = 1'b1;
        f_addr = 12'h006;
        tick();
        f_req = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b1 || f_misalign !== 1'b1 || f_inst !== 32'h0 || f_inst_le !== 32'h0) begin
            n_bad++;
            $display("FAIL misalign: got v=%b mis=%b inst=%h want 1/1/00000000",
                     f_valid, f_misalign, f_inst);
        end
        tick();
        n_cmp++;
        if (f_valid !== 1'b0 || f_misalign !== 1'b1 || f_inst !== 32'h0) begin
            n_bad++;
            $display("FAIL misalign_hold: got v=%b mis=%b inst=%h want 0/1/00000000",
                     f_valid, f_misalign, f_inst);
        end
    endtask

    task automatic test_restart();
        start_load(2);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        // Restart with a byte offered in the same cycle: that byte must be dropped
        ld_valid = 1'b1;
        ld_byte  = 8'h55;
        start_load(1);
        ld_valid = 1'b0;
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        n_cmp++;
        if (ld_done !== 1'b0 || ld_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_mid: got done=%b rdy=%b want 0/1", ld_done, ld_ready);
        end
        push_byte(8'hDD);
        set_word(0, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        n_cmp++;
        if (ld_done !== 1'b1 || ld_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_done: got done=%b rdy=%b want 1/0", ld_done, ld_ready);
        end
        f_req  = 1'b1;
        f_addr = 12'h000;
        tick();
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== 32'hAABBCCDD || f_inst_le !== 32'hDDCCBBAA) begin
            n_bad++;
            $display("FAIL restart_word0: got v=%b be=%h le=%h want 1/aabbccdd/ddccbbaa",
                     f_valid, f_inst, f_inst_le);
        end
        f_addr = 12'h004;
        tick();
        f_req = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== 32'h0100006F) begin
            n_bad++;
            $display("FAIL restart_word1: got v=%b inst=%h want 1/0100006f", f_valid, f_inst);
        end
    endtask

    task automatic test_fetch_on_ldstart();
        logic [7:0] b [4];
        logic [31:0] old_be;
        old_be    = mdl_be[0];
        ld_start  = 1'b1;
        ld_nwords = 11'd1;
        f_req     = 1'b1;
        f_addr    = 12'h000;
        tick();
        ld_start = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== old_be || ld_ready !== 1'b1 || f_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_at_ldstart: got v=%b inst=%h rdy=%b frdy=%b want 1/%h/1/0",
                     f_valid, f_inst, ld_ready, f_ready, old_be);
        end
        tick();
        f_req = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b0 || f_inst !== old_be) begin
            n_bad++;
            $display("FAIL fetch_in_load: got v=%b inst=%h want 0/%h", f_valid, f_inst, old_be);
        end
        for (int k = 0; k < 4; k++) begin
            b[k] = 8'($urandom);
            push_byte(b[k]);
        end
        set_word(0, b[0], b[1], b[2], b[3]);
        f_req  = 1'b1;
        f_addr = 12'h000;
        tick();
        f_req = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== mdl_be[0] || f_inst_le !== mdl_le[0]) begin
            n_bad++;
            $display("FAIL reload_word0: got v=%b be=%h le=%h want 1/%h/%h",
                     f_valid, f_inst, f_inst_le, mdl_be[0], mdl_le[0]);
        end
    endtask

    task automatic test_rst_midload();
        logic [7:0] b [5];
        start_load(3);
        for (int k = 0; k < 5; k++) begin
            b[k] = 8'($urandom);
            push_byte(b[k]);
        end
        set_word(0, b[0], b[1], b[2], b[3]);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ld_ready, ld_done, f_ready, f_valid, f_misalign} !== 5'b0 || f_inst !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_midload: got rdy=%b done=%b frdy=%b fv=%b mis=%b inst=%h want all 0",
                     ld_ready, ld_done, f_ready, f_valid, f_misalign, f_inst);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (ld_ready !== 1'b0 || f_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idle: got rdy=%b frdy=%b want 0/0", ld_ready, f_ready);
        end
    endtask

    task automatic test_zero_load();
        ld_valid = 1'b1;
        ld_byte  = 8'hE1;
        start_load(0);
        n_cmp++;
        if (ld_done !== 1'b1 || f_ready !== 1'b1 || ld_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_load: got done=%b frdy=%b rdy=%b want 1/1/0",
                     ld_done, f_ready, ld_ready);
        end
        // Bytes offered in RUN must be ignored
        for (int k = 0; k < 4; k++) push_byte(8'hF0 + 8'(k));
        f_req  = 1'b1;
        f_addr = 12'h000;
        tick();
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== mdl_be[0] || f_inst_le !== mdl_le[0]) begin
            n_bad++;
            $display("FAIL zero_word0: got v=%b be=%h le=%h want 1/%h/%h",
                     f_valid, f_inst, f_inst_le, mdl_be[0], mdl_le[0]);
        end
        f_addr = 12'h004;
        tick();
        f_req = 1'b0;
        n_cmp++;
        if (f_valid !== 1'b1 || f_inst !== mdl_be[1]) begin
            n_bad++;
            $display("FAIL zero_word1: got v=%b inst=%h want 1/%h", f_valid, f_inst, mdl_be[1]);
        end
    endtask

    task automatic test_random();
        logic [7:0]  b [4];
        logic [31:0] exp_be, exp_le;
        int n, idx, mis;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 16);
            start_load(n);
            for (int w = 0; w < n; w++) begin
                for (int k = 0; k < 4; k++) begin
                    while ($urandom_range(0, 3) == 0) tick();
                    b[k] = 8'($urandom);
                    push_byte(b[k]);
                end
                set_word(w, b[0], b[1], b[2], b[3]);
            end
            n_cmp++;
            if (ld_done !== 1'b1 || ld_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_load_done r=%0d: got done=%b rdy=%b want 1/0",
                         r, ld_done, ld_ready);
            end
            exp_be = 32'h0;
            for (int j = 0; j < 12; j++) begin
                idx      = $urandom_range(0, n - 1);
                mis      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                exp_be   = (mis != 0) ? 32'h0 : mdl_be[idx];
                exp_le   = (mis != 0) ? 32'h0 : mdl_le[idx];
                ld_valid = 1'($urandom);
                ld_byte  = 8'($urandom);
                f_req    = 1'b1;
                f_addr   = 12'(idx * 4 + mis);
                tick();
                f_req = 1'b0;
                n_cmp++;
                if (f_valid !== 1'b1 || f_misalign !== (mis != 0) || f_inst !== exp_be ||
                    f_inst_le !== exp_le) begin
                    n_bad++;
                    $display("FAIL rand_fetch a=%h: got v=%b mis=%b be=%h le=%h want 1/%b/%h/%h",
                             f_addr, f_valid, f_misalign, f_inst, f_inst_le, mis != 0,
                             exp_be, exp_le);
                end
                if ($urandom_range(0, 2) == 0) begin
                    tick();
                    n_cmp++;
                    if (f_valid !== 1'b0 || f_inst !== exp_be) begin
                        n_bad++;
                        $display("FAIL rand_gap: got v=%b inst=%h want 0/%h",
                                 f_valid, f_inst, exp_be);
                    end
                end
            end
            ld_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_idle_fetch();
        test_load_fetch();
        test_misalign();
        test_restart();
        test_fetch_on_ldstart();
        test_rst_midload();
        test_zero_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
